channel_sequencer: RTL and testbench

Selects the active display channel (0 red, 1 green, 2 blue) and drives `curr_channel` into the RGB LED manager and the visualizer datapath. Two raw board buttons are synchronized and debounced on-chip: `btn_next` advances the channel, `btn_mode` toggles between manual selection and automatic timed cycling. A one-cycle strobe flags each channel change so downstream blocks can restart their accumulation.

---
 rtl/visualizer_pkg.sv | 9 +
 rtl/button_debouncer.sv | 35 +++
 rtl/channel_sequencer.sv | 54 +++++
 tb/tb_channel_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/visualizer_pkg.sv
// visualizer_pkg: shared state type, channel width and channel indices
// used by the sequencer and the RGB LED manager.
package visualizer_pkg;
   localparam int CHANNEL_W = 2;
   localparam logic [CHANNEL_W-1:0] CH_RED = 2'd0;
   localparam logic [CHANNEL_W-1:0] CH_GREEN = 2'd1;
   localparam logic [CHANNEL_W-1:0] CH_BLUE = 2'd2;
   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} seq_state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, stable-count debounce and a
// registered one-cycle pulse on each accepted press.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic level_d;
   logic mismatch;
   logic accept;
   assign mismatch = sync[1] ^ btn_level;
   assign accept = mismatch && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         cnt <= '0;
         btn_level <= 1'b0;
         level_d <= 1'b0;
         btn_press <= 1'b0;
      end else begin
         sync <= {sync[0], btn_raw};
         cnt <= (mismatch && !accept) ? cnt + CW'(1) : '0;
         btn_level <= accept ? sync[1] : btn_level;
         level_d <= btn_level;
         btn_press <= btn_level & ~level_d;
      end
   end
endmodule

// File: rtl/channel_sequencer.sv
// channel_sequencer: manual/auto channel selection driven by two debounced
// buttons, with a dwell timer for auto cycling and a change strobe.
module channel_sequencer
   import visualizer_pkg::*;
#(
   parameter int NUM_CHANNELS = 3,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_next,
   input  logic btn_mode,
   output logic [CHANNEL_W-1:0] curr_channel,
   output logic auto_mode,
   output logic channel_changed
);
   localparam int DW = $clog2(DWELL_CYCLES);
   seq_state_t state, state_next;
   logic [DW-1:0] dwell, dwell_next;
   logic [1:0] levels_unused;
   logic next_press, mode_press, dwell_term, advance;
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk(clk), .reset(reset), .btn_raw(btn_next),
      .btn_level(levels_unused[0]), .btn_press(next_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .reset(reset), .btn_raw(btn_mode),
      .btn_level(levels_unused[1]), .btn_press(mode_press)
   );
   // Terminal is qualified by the current state, so it still advances on the
   // same cycle a mode press drops back to MANUAL.
   always_comb begin
      dwell_term = (state == AUTO) && (dwell == DW'(DWELL_CYCLES - 1));
      advance = next_press || dwell_term;
      state_next = mode_press ? ((state == AUTO) ? MANUAL : AUTO) : state;
      dwell_next = (state == MANUAL || mode_press || advance) ? '0 : dwell + DW'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MANUAL;
         dwell <= '0;
         curr_channel <= CH_RED;
         channel_changed <= 1'b0;
      end else begin
         state <= state_next;
         dwell <= dwell_next;
         channel_changed <= advance;
         if (advance)
            curr_channel <= (curr_channel == CHANNEL_W'(NUM_CHANNELS - 1)) ? CH_RED : curr_channel + CHANNEL_W'(1);
      end
   end
   assign auto_mode = (state == AUTO);
endmodule

// File: tb/tb_channel_sequencer.sv
// tb_channel_sequencer: directed scenarios with hand-computed cycle indices
// (DEBOUNCE_CYCLES=4, DWELL_CYCLES=10).
module tb_channel_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_next = 1'b0;
   logic btn_mode = 1'b0;
   logic [1:0] curr_channel;
   logic auto_mode;
   logic channel_changed;
   int checks = 0;
   int failures = 0;
   int it, n_chg, n_pulse, bad;
   int chg_at [16];
   logic [1:0] chg_val [16];
   logic [1:0] prev;

   channel_sequencer #(.NUM_CHANNELS(3), .DEBOUNCE_CYCLES(4), .DWELL_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .btn_next(btn_next), .btn_mode(btn_mode),
      .curr_channel(curr_channel), .auto_mode(auto_mode), .channel_changed(channel_changed)
   );

   always #5 clk = ~clk;

   // One cycle: advance to the next falling edge and log channel activity.
   task automatic step();
      @(negedge clk);
      it++;
      if (curr_channel !== prev) begin
         if (n_chg < 16) begin
            chg_at[n_chg] = it;
            chg_val[n_chg] = curr_channel;
         end
         n_chg++;
      end
      if (channel_changed === 1'b1) n_pulse++;
      if (channel_changed !== (curr_channel !== prev)) bad++;
      if (curr_channel === 2'd3) bad++;
      prev = curr_channel;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      it = 0; n_chg = 0; n_pulse = 0; bad = 0; prev = curr_channel;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      btn_next = 0; btn_mode = 0;
      do_reset(3);
      checks++; if (curr_channel !== 2'd0) begin failures++; $display("FAIL reset_channel got %0d want 0", curr_channel); end
      checks++; if (auto_mode !== 1'b0) begin failures++; $display("FAIL reset_auto got %b want 0", auto_mode); end
      checks++; if (channel_changed !== 1'b0) begin failures++; $display("FAIL reset_changed got %b want 0", channel_changed); end
      clear_log();
      steps(50);
      checks++; if (n_chg !== 0 || n_pulse !== 0 || bad !== 0) begin failures++; $display("FAIL reset_idle got chg=%0d pulses=%0d bad=%0d want 0/0/0", n_chg, n_pulse, bad); end
      checks++; if (auto_mode !== 1'b0) begin failures++; $display("FAIL reset_idle_auto got %b want 0", auto_mode); end
   endtask

   task automatic test_manual_advance();
      logic [1:0] exp_ch [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
      for (int p = 0; p < 4; p++) begin
         clear_log();
         btn_next = 1; steps(20);
         btn_next = 0; steps(20);
         checks++; if (n_chg !== 1 || n_pulse !== 1 || bad !== 0) begin failures++; $display("FAIL manual_count press %0d got chg=%0d pulses=%0d bad=%0d want 1/1/0", p, n_chg, n_pulse, bad); end
         checks++; if (chg_at[0] !== 8) begin failures++; $display("FAIL manual_latency press %0d got %0d want 8", p, chg_at[0]); end
         checks++; if (chg_val[0] !== exp_ch[p]) begin failures++; $display("FAIL manual_channel press %0d got %0d want %0d", p, chg_val[0], exp_ch[p]); end
      end
   endtask

   task automatic test_glitch();
      clear_log();
      btn_next = 1; steps(3);
      btn_next = 0; steps(20);
      checks++; if (n_chg !== 0 || n_pulse !== 0) begin failures++; $display("FAIL glitch_short got chg=%0d pulses=%0d want 0/0", n_chg, n_pulse); end
      clear_log();
      btn_next = 1; step(); btn_next = 0; step(); btn_next = 1; step(); btn_next = 0; step();
      btn_next = 1; steps(20);
      btn_next = 0; steps(20);
      checks++; if (n_chg !== 1 || n_pulse !== 1 || bad !== 0) begin failures++; $display("FAIL glitch_bounce_count got chg=%0d pulses=%0d bad=%0d want 1/1/0", n_chg, n_pulse, bad); end
      checks++; if (chg_at[0] !== 12 || chg_val[0] !== 2'd2) begin failures++; $display("FAIL glitch_bounce_adv got at=%0d ch=%0d want at=12 ch=2", chg_at[0], chg_val[0]); end
   endtask

   task automatic test_auto_cycling();
      int exp_at [4] = '{18, 28, 38, 48};
      logic [1:0] exp_ch [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
      do_reset(2);
      clear_log();
      btn_mode = 1; steps(7);
      checks++; if (auto_mode !== 1'b0) begin failures++; $display("FAIL auto_early got %b want 0", auto_mode); end
      step();
      checks++; if (auto_mode !== 1'b1) begin failures++; $display("FAIL auto_enter got %b want 1", auto_mode); end
      steps(12);
      btn_mode = 0; steps(20);
      btn_mode = 1; steps(7);
      checks++; if (auto_mode !== 1'b1) begin failures++; $display("FAIL auto_hold got %b want 1", auto_mode); end
      step();
      // Mode exit lands on the dwell terminal: the advance must still happen.
      checks++; if (auto_mode !== 1'b0 || curr_channel !== 2'd1 || channel_changed !== 1'b1) begin failures++; $display("FAIL auto_exit_terminal got auto=%b ch=%0d chg=%b want 0/1/1", auto_mode, curr_channel, channel_changed); end
      steps(12);
      btn_mode = 0; steps(30);
      checks++; if (n_chg !== 4 || n_pulse !== 4 || bad !== 0 || auto_mode !== 1'b0) begin failures++; $display("FAIL auto_count got chg=%0d pulses=%0d bad=%0d auto=%b want 4/4/0/0", n_chg, n_pulse, bad, auto_mode); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (chg_at[k] !== exp_at[k] || chg_val[k] !== exp_ch[k]) begin failures++; $display("FAIL auto_adv %0d got at=%0d ch=%0d want at=%0d ch=%0d", k, chg_at[k], chg_val[k], exp_at[k], exp_ch[k]); end
      end
   endtask

   task automatic test_collision();
      int exp_at [6] = '{18, 28, 38, 48, 50, 60};
      logic [1:0] exp_ch [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
      do_reset(2);
      clear_log();
      btn_mode = 1; steps(20);
      btn_mode = 0; btn_next = 1; steps(10);
      btn_next = 0; steps(12);
      btn_next = 1; steps(13);
      btn_next = 0; steps(10);
      checks++; if (n_chg !== 6 || n_pulse !== 6 || bad !== 0) begin failures++; $display("FAIL collision_count got chg=%0d pulses=%0d bad=%0d want 6/6/0", n_chg, n_pulse, bad); end
      for (int k = 0; k < 6; k++) begin
         checks++; if (chg_at[k] !== exp_at[k] || chg_val[k] !== exp_ch[k]) begin failures++; $display("FAIL collision_adv %0d got at=%0d ch=%0d want at=%0d ch=%0d", k, chg_at[k], chg_val[k], exp_at[k], exp_ch[k]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      clear_log();
      btn_mode = 1; steps(20);
      btn_mode = 0; steps(15);
      checks++; if (curr_channel !== 2'd2 || auto_mode !== 1'b1) begin failures++; $display("FAIL mid_setup got ch=%0d auto=%b want 2/1", curr_channel, auto_mode); end
      do_reset(2);
      checks++; if (curr_channel !== 2'd0 || auto_mode !== 1'b0 || channel_changed !== 1'b0) begin failures++; $display("FAIL mid_reset got ch=%0d auto=%b chg=%b want 0/0/0", curr_channel, auto_mode, channel_changed); end
      clear_log();
      steps(40);
      checks++; if (n_chg !== 0 || n_pulse !== 0 || auto_mode !== 1'b0) begin failures++; $display("FAIL mid_after got chg=%0d pulses=%0d auto=%b want 0/0/0", n_chg, n_pulse, auto_mode); end
   endtask

   initial begin
      test_reset();
      test_manual_advance();
      test_glitch();
      test_auto_cycling();
      test_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
